// File: rtl/ps2_packet_bit_counter.sv
// PS/2 receive framer: counts host-sampled PS/2 falling edges, deframes start/data/parity/stop and groups frames into packets.
// Latency: one clk; a falling_edge sampled at edge N is reflected in counters, data_out and pulses right after edge N.
// Backpressure: none; every falling_edge is consumed in the cycle it arrives, the downstream decoder must keep up.
//
// Ports:
//   clk, reset        system clock and synchronous active-high reset (clears everything, including data_out)
//   bit_reset         synchronous abort of the current packet; clears counters, keeps data_out, no pulse
//   falling_edge      one-cycle strobe from the PS/2 clock edge detector
//   ps2_data          synchronised PS/2 data, meaningful when falling_edge=1
//   bit_counter       frame_index*F + bit_index; zero means idle (watchdog stopped)
//   bit_index         position within the current frame (0 = waiting for start bit)
//   frame_index       frame number within the current packet
//   data_out          payload of the last good frame, held until the next good frame
//   frame_done        pulse: good frame, data_out updated
//   packet_done       pulse together with frame_done of the last frame in a packet
//   frame_error       pulse: bad parity or stop bit, packet aborted
//   timeout           pulse: no falling edge for TIMEOUT_CYCLES cycles mid-packet, packet aborted

module ps2_packet_bit_counter #(
    parameter  int DATA_BITS         = 8,
    parameter  int FRAMES_PER_PACKET = 3,
    parameter  int TIMEOUT_CYCLES    = 5000,
    parameter  int CNT_W             = 7,
    localparam int F                 = DATA_BITS + 3,
    localparam int BI_W              = $clog2(F),
    localparam int FI_W              = (FRAMES_PER_PACKET > 1) ? $clog2(FRAMES_PER_PACKET) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bit_reset,
    input  logic                 falling_edge,
    input  logic                 ps2_data,
    output logic [CNT_W-1:0]     bit_counter,
    output logic [BI_W-1:0]      bit_index,
    output logic [FI_W-1:0]      frame_index,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 frame_done,
    output logic                 packet_done,
    output logic                 frame_error,
    output logic                 timeout
);

    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [BI_W-1:0] BI_DATA_LAST = BI_W'(DATA_BITS);
    localparam logic [BI_W-1:0] BI_PARITY    = BI_W'(DATA_BITS + 1);
    localparam logic [BI_W-1:0] BI_STOP      = BI_W'(F - 1);
    localparam logic [FI_W-1:0] FI_LAST      = FI_W'(FRAMES_PER_PACKET - 1);
    localparam logic [WD_W-1:0] WD_LAST      = WD_W'(TIMEOUT_CYCLES - 1);

    logic [DATA_BITS-1:0] shreg;
    logic                 parity_bit;
    logic [WD_W-1:0]      wd_cnt;
    logic                 in_recv;
    logic                 parity_ok;
    logic                 wd_expired;

    // bit_counter doubles as the IDLE/RECV state: zero means no packet in progress.
    assign in_recv    = (bit_counter != '0);
    assign parity_ok  = ^{shreg, parity_bit};
    // An edge in the expiry cycle wins over the watchdog.
    assign wd_expired = in_recv && !falling_edge && (wd_cnt == WD_LAST);

    always_ff @(posedge clk) begin
        frame_done  <= 1'b0;
        packet_done <= 1'b0;
        frame_error <= 1'b0;
        timeout     <= 1'b0;

        if (reset) begin
            bit_counter <= '0;
            bit_index   <= '0;
            frame_index <= '0;
            shreg       <= '0;
            parity_bit  <= 1'b0;
            wd_cnt      <= '0;
            data_out    <= '0;
        end else if (bit_reset) begin
            bit_counter <= '0;
            bit_index   <= '0;
            frame_index <= '0;
            shreg       <= '0;
            parity_bit  <= 1'b0;
            wd_cnt      <= '0;
        end else if (wd_expired) begin
            timeout     <= 1'b1;
            bit_counter <= '0;
            bit_index   <= '0;
            frame_index <= '0;
            wd_cnt      <= '0;
        end else begin
            if (falling_edge || !in_recv) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end

            if (falling_edge) begin
                if (bit_index == '0) begin
                    // A high start bit is line noise: stay put so the next low bit realigns the frame.
                    if (!ps2_data) begin
                        bit_index   <= bit_index + 1'b1;
                        bit_counter <= bit_counter + 1'b1;
                    end
                end else if (bit_index <= BI_DATA_LAST) begin
                    // LSB arrives first, so shifting in from the top leaves the byte in natural order.
                    shreg       <= {ps2_data, shreg[DATA_BITS-1:1]};
                    bit_index   <= bit_index + 1'b1;
                    bit_counter <= bit_counter + 1'b1;
                end else if (bit_index == BI_PARITY) begin
                    parity_bit  <= ps2_data;
                    bit_index   <= bit_index + 1'b1;
                    bit_counter <= bit_counter + 1'b1;
                end else if (bit_index == BI_STOP) begin
                    bit_index <= '0;
                    if (ps2_data && parity_ok) begin
                        data_out   <= shreg;
                        frame_done <= 1'b1;
                        if (frame_index == FI_LAST) begin
                            packet_done <= 1'b1;
                            frame_index <= '0;
                            bit_counter <= '0;
                        end else begin
                            // (frame_index+1)*F + 0 is exactly one past the stop position.
                            frame_index <= frame_index + 1'b1;
                            bit_counter <= bit_counter + 1'b1;
                        end
                    end else begin
                        frame_error <= 1'b1;
                        frame_index <= '0;
                        bit_counter <= '0;
                    end
                end else begin
                    // Unreachable index values: fall back to waiting for a start bit.
                    bit_index   <= '0;
                    frame_index <= '0;
                    bit_counter <= '0;
                end
            end
        end
    end

endmodule

// File: doc/ps2_packet_bit_counter.md
# ps2_packet_bit_counter

Parametrised PS/2 receive framer that replaces the plain bit counter in the mouse path. It counts host-sampled PS/2 clock falling edges, shifts in data bits, checks start, parity and stop per frame, and groups frames into multi-byte packets. Bytes are delivered with per-frame and per-packet strobes. An inter-bit watchdog resynchronises after lost clocks. It sits between the PS/2 clock edge detector and the mouse packet decoder.

## Interface
- DATA_BITS, 8, payload bits per frame; frame length F = DATA_BITS+3 (start, data LSB first, odd parity, stop)
- FRAMES_PER_PACKET, 3, frames per packet (3 = standard mouse, 4 = wheel mouse)
- TIMEOUT_CYCLES, 5000, clk cycles without a falling edge mid-packet before abort (≥2)
- CNT_W, 7, width of bit_counter; must hold F*FRAMES_PER_PACKET-1
- clk  in  1  system clock; all logic on posedge clk
- reset  in  1  synchronous, active-high; clears everything
- bit_reset  in  1  synchronous, active-high; aborts the current packet and clears counters
- falling_edge  in  1  one-cycle strobe: PS/2 clock falling edge detected this cycle
- ps2_data  in  1  synchronised PS/2 data, valid in any cycle with falling_edge=1
- bit_counter  out  CNT_W  bit position in packet = frame_index*F + bit_index
- bit_index  out  $clog2(F)  bit position within current frame
- frame_index  out  $clog2(FRAMES_PER_PACKET)  current frame within packet
- data_out  out  DATA_BITS  last completed frame payload; held until next frame_done
- frame_done  out  1  one-cycle pulse: frame received without error, data_out updated
- packet_done  out  1  one-cycle pulse coincident with frame_done of the last frame
- frame_error  out  1  one-cycle pulse: parity or stop failure; packet aborted
- timeout  out  1  one-cycle pulse: watchdog expired mid-packet; packet aborted

## Operation
- Two states: IDLE (bit_counter==0, watchdog stopped) and RECV (bit_counter!=0, watchdog running).
- Priority per clock: reset > bit_reset > watchdog expiry > falling_edge.
- Start bit, sampled when bit_index==0: ps2_data=0 advances bit_index to 1. ps2_data=1 is ignored: no count, no error, counters unchanged. This resyncs on a glitch.
- Data bits, bit_index 1..DATA_BITS: shift ps2_data into the shift register MSB side. After DATA_BITS shifts the register holds the LSB-first byte.
- Parity bit, bit_index DATA_BITS+1: sample and store it. Parity is OK when the XOR of data and parity equals 1.
- Stop bit, bit_index F-1: on the edge, bit_index wraps to 0.
  - Stop=1 and parity OK: load data_out, pulse frame_done, increment frame_index. If frame_index was FRAMES_PER_PACKET-1, also pulse packet_done and wrap frame_index to 0.
  - Otherwise: pulse frame_error, clear frame_index and bit_index, leave data_out unchanged.
- Watchdog:
  - Counts clk cycles in RECV, cleared on every falling_edge.
  - Reaching TIMEOUT_CYCLES-1 with no edge in that cycle: pulse timeout, clear bit_index and frame_index, return to IDLE.
  - An edge in the expiry cycle prevents the timeout.
- bit_reset and reset both clear bit_index, frame_index, shift register and watchdog, and drop any same-cycle falling_edge. reset also clears data_out. bit_reset produces no pulse.
- Reset values: all outputs 0.

## Timing
- All outputs are registered. A falling_edge at clock edge N produces the updated counters and any frame_done, packet_done or frame_error pulse visible after edge N.
- Pulses last exactly one cycle. Back-to-back frames need no idle cycle: the next start bit may arrive on the first falling_edge after frame_done.
- data_out is stable from its update until the next successful frame.
- timeout asserts exactly TIMEOUT_CYCLES cycles after the last falling_edge.
- Mid-packet reset or bit_reset: the next cycle shows zeroed counters. A partial packet never produces packet_done.

## Test plan
- Defaults; frames 0x08 (parity 0), 0x05 (parity 1), 0xFB (parity 0), stop=1 each -> frame_done x3 with data_out 0x08, 0x05, 0xFB; packet_done with third frame; bit_counter steps 0..32 then 0.
- FRAMES_PER_PACKET=4; four valid frames 0x08,0x00,0x00,0x01 -> packet_done only on the 4th; frame_index 0,1,2,3,0.
- Frame 0x05 with parity 0 -> frame_error pulse, no frame_done, frame_index=0, data_out keeps prior value. Same with stop=0.
- Start bit 1 on three edges, then a valid frame 0x08 -> no count on the three edges; frame_done with 0x08.
- Stop clocking after 5 bits -> timeout exactly 5000 cycles after the last edge, bit_counter=0. An edge at cycle 4999 -> no timeout.
- bit_reset asserted together with falling_edge at bit 7 of frame 2 -> edge dropped, counters 0, no pulses; next full packet received correctly. Repeat with reset -> data_out=0.
